// File: rtl/oled_text_render.sv
// Renders a frame of 2-page-tall glyphs into SSD1306-style IIC command/data words.
// Each glyph emits page/lo/hi addressing followed by W font bytes, for row 0 then row 1.
module oled_text_render #(
    parameter int unsigned MAX_GLYPHS = 16,
    parameter logic [7:0]  IIC_ADDR   = 8'h78,
    parameter int unsigned FONT_SEL_W = 6
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [6:0]              glyph_count,
    output logic [5:0]              desc_idx,
    input  logic [12+FONT_SEL_W-1:0] desc_in,
    output logic [FONT_SEL_W+4:0]   rom_addr,
    input  logic [7:0]              rom_data,
    output logic                    cmd_valid,
    output logic [23:0]             cmd_data,
    input  logic                    write_done,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned DESC_W  = 12 + FONT_SEL_W;
    localparam int unsigned ROM_AW  = FONT_SEL_W + 5;
    localparam logic [6:0]  MAX_CNT = 7'(MAX_GLYPHS);

    typedef enum logic [2:0] {
        IDLE, LOAD, SETPAGE, SETLO, SETHI, FETCH, DATA, FIN
    } state_t;

    state_t state_q, state_d;

    logic [6:0]            count_q, count_d;
    logic [5:0]            glyph_q, glyph_d;
    logic                  row_q, row_d;
    logic [3:0]            col_q, col_d;
    logic [DESC_W-1:0]     desc_q, desc_d;

    logic                  cmd_valid_d;
    logic [23:0]           cmd_data_d;
    logic [ROM_AW-1:0]     rom_addr_d;
    logic [5:0]            desc_idx_d;
    logic                  busy_d;
    logic                  done_d;

    logic [7:0]            x_d;
    logic [2:0]            page_d;
    logic [FONT_SEL_W-1:0] sel_d;
    logic                  wide_q;
    logic [3:0]            last_col;

    // Descriptor is latched on the LOAD cycle; later states see the held copy.
    assign desc_d   = (state_q == LOAD) ? desc_in : desc_q;
    assign x_d      = desc_d[DESC_W-1 -: 8];
    assign page_d   = desc_d[FONT_SEL_W+1 +: 3];
    assign sel_d    = desc_d[FONT_SEL_W-1:0];
    assign wide_q   = desc_q[FONT_SEL_W];
    assign last_col = wide_q ? 4'd15 : 4'd7;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            count_q   <= 7'd0;
            glyph_q   <= 6'd0;
            row_q     <= 1'b0;
            col_q     <= 4'd0;
            desc_q    <= '0;
            cmd_valid <= 1'b0;
            cmd_data  <= 24'h0;
            rom_addr  <= '0;
            desc_idx  <= 6'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            count_q   <= count_d;
            glyph_q   <= glyph_d;
            row_q     <= row_d;
            col_q     <= col_d;
            desc_q    <= desc_d;
            cmd_valid <= cmd_valid_d;
            cmd_data  <= cmd_data_d;
            rom_addr  <= rom_addr_d;
            desc_idx  <= desc_idx_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Next-state and counter sequencing; outputs are derived from the next state
    // so that every output port comes straight from a flop.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        glyph_d = glyph_q;
        row_d   = row_q;
        col_d   = col_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = (glyph_count > MAX_CNT) ? MAX_CNT : glyph_count;
                    glyph_d = 6'd0;
                    row_d   = 1'b0;
                    col_d   = 4'd0;
                    state_d = (count_d == 7'd0) ? FIN : LOAD;
                end
            end
            LOAD:    state_d = SETPAGE;
            SETPAGE: if (cmd_valid && write_done) state_d = SETLO;
            SETLO:   if (cmd_valid && write_done) state_d = SETHI;
            SETHI:   if (cmd_valid && write_done) state_d = FETCH;
            FETCH:   state_d = DATA;
            DATA: begin
                if (cmd_valid && write_done) begin
                    if (col_q != last_col) begin
                        col_d   = col_q + 4'd1;
                        state_d = FETCH;
                    end else if (!row_q) begin
                        row_d   = 1'b1;
                        col_d   = 4'd0;
                        state_d = SETPAGE;
                    end else if ((7'(glyph_q) + 7'd1) < count_q) begin
                        glyph_d = glyph_q + 6'd1;
                        row_d   = 1'b0;
                        col_d   = 4'd0;
                        state_d = LOAD;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
        end

        busy_d      = (state_d != IDLE);
        done_d      = (state_d == FIN);
        desc_idx_d  = glyph_d;
        rom_addr_d  = rom_addr;
        cmd_valid_d = 1'b0;
        cmd_data_d  = cmd_data;

        case (state_d)
            SETPAGE: begin
                cmd_valid_d = 1'b1;
                cmd_data_d  = {IIC_ADDR, 8'h00, 5'b10110, page_d + 3'(row_d)};
            end
            SETLO: begin
                cmd_valid_d = 1'b1;
                cmd_data_d  = {IIC_ADDR, 8'h00, 4'h0, x_d[3:0]};
            end
            SETHI: begin
                cmd_valid_d = 1'b1;
                cmd_data_d  = {IIC_ADDR, 8'h00, 4'h1, x_d[7:4]};
            end
            FETCH: begin
                rom_addr_d = {sel_d, row_d, col_d};
            end
            DATA: begin
                cmd_valid_d = 1'b1;
                // Capture the font byte only on entry so the word stays stable until consumed.
                if (state_q != DATA) begin
                    cmd_data_d = {IIC_ADDR, 8'h40, rom_data};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oled_text_render.sv
// Directed bench for oled_text_render: drives frames through an IIC-writer stand-in
// and checks every emitted word against hand values and a small frame model.
module tb_oled_text_render;

    logic        sys_clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [6:0]  glyph_count;
    logic [5:0]  desc_idx;
    logic [17:0] desc_in;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;
    logic        cmd_valid;
    logic [23:0] cmd_data;
    logic        write_done;
    logic        busy;
    logic        done;

    logic [17:0] desc_tbl [64];
    logic [23:0] got_q [$];
    logic [23:0] exp_q [$];

    int total = 0;
    int bad   = 0;

    oled_text_render #(
        .MAX_GLYPHS(16),
        .IIC_ADDR  (8'h78),
        .FONT_SEL_W(6)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .glyph_count(glyph_count),
        .desc_idx   (desc_idx),
        .desc_in    (desc_in),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .write_done (write_done),
        .busy       (busy),
        .done       (done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [7:0] rom_fn(input logic [10:0] a);
        logic [10:0] t;
        t = a ^ (a >> 3);
        return t[7:0] ^ 8'h3C;
    endfunction

    assign rom_data = rom_fn(rom_addr);
    assign desc_in  = desc_tbl[desc_idx];

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] word_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 24'hx;
    endfunction

    // Reference word stream for the first n descriptors of desc_tbl.
    task automatic build_exp(input int n);
        logic [17:0] d;
        logic [2:0]  pg;
        int          w;
        exp_q.delete();
        for (int g = 0; g < n; g++) begin
            d = desc_tbl[g];
            w = d[6] ? 16 : 8;
            for (int r = 0; r < 2; r++) begin
                pg = d[9:7] + 3'(r);
                exp_q.push_back({8'h78, 8'h00, 5'b10110, pg});
                exp_q.push_back({8'h78, 8'h00, 4'h0, d[13:10]});
                exp_q.push_back({8'h78, 8'h00, 4'h1, d[17:14]});
                for (int c = 0; c < w; c++) begin
                    exp_q.push_back({8'h78, 8'h40, rom_fn(11'(d[5:0] * 32 + r * 16 + c))});
                end
            end
        end
    endtask

    task automatic compare_model(input string name, input int n);
        build_exp(n);
        check({name, "_nwords"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_w%0d", name, i), word_at(i), exp_q[i]);
        end
    endtask

    task automatic pulse_start(input logic [6:0] n);
        start       = 1'b1;
        glyph_count = n;
        step();
        start = 1'b0;
    endtask

    // Writer stand-in: consumes each presented word on its third valid cycle.
    // Optionally pulses write_done while cmd_valid is low, or cuts the frame at a word index.
    task automatic serve(input int budget, input int cut_word, input bit cut_abort,
                         input bit idle_wd, output int done_cnt, output bit timed_out);
        int wcnt;
        wcnt      = 0;
        done_cnt  = 0;
        timed_out = 1'b1;
        got_q.delete();
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (done) done_cnt++;
            if (!busy) begin
                timed_out  = 1'b0;
                write_done = 1'b0;
                return;
            end
            if (cmd_valid) begin
                if (got_q.size() == cut_word) begin
                    timed_out = 1'b0;
                    if (cut_abort) begin
                        abort      = 1'b1;
                        write_done = 1'b1;
                        step();
                        abort = 1'b0;
                    end
                    write_done = 1'b0;
                    return;
                end
                wcnt++;
                if (wcnt == 3) begin
                    write_done = 1'b1;
                    got_q.push_back(cmd_data);
                    wcnt = 0;
                end else begin
                    write_done = 1'b0;
                end
            end else begin
                wcnt       = 0;
                write_done = idle_wd;
            end
            step();
        end
        write_done = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_cmd_valid"}, cmd_valid, 0);
        check({name, "_cmd_data"}, cmd_data, 0);
        check({name, "_done"}, done, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_desc_idx"}, desc_idx, 0);
        check({name, "_rom_addr"}, rom_addr, 0);
    endtask

    initial begin
        int dcnt;
        bit tmo;
        int dsum;

        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        write_done  = 1'b0;
        glyph_count = 7'd0;
        for (int i = 0; i < 64; i++) desc_tbl[i] = 18'h0;

        // Reset values, with a start request that must be ignored under reset.
        step();
        start = 1'b1;
        glyph_count = 7'd1;
        step();
        start = 1'b0;
        check_reset_outputs("reset");
        rst = 1'b0;
        step();
        check("post_reset_idle", busy, 0);

        // Single narrow glyph, write_done pulsed whenever nothing is presented.
        desc_tbl[0] = {8'd8, 3'd0, 1'b0, 6'd2};
        pulse_start(7'd1);
        check("narrow_busy", busy, 1);
        serve(2000, -1, 1'b0, 1'b1, dcnt, tmo);
        check("narrow_timeout", tmo, 0);
        check("narrow_done_cnt", dcnt, 1);
        check("narrow_page0", word_at(0), 24'h7800B0);
        check("narrow_lo0", word_at(1), 24'h780008);
        check("narrow_hi0", word_at(2), 24'h780010);
        check("narrow_data0", word_at(3), 24'h784074);
        check("narrow_page1", word_at(11), 24'h7800B1);
        check("narrow_lo1", word_at(12), 24'h780008);
        check("narrow_hi1", word_at(13), 24'h780010);
        check("narrow_data8", word_at(14), 24'h784066);
        compare_model("narrow", 1);

        // Single wide glyph.
        desc_tbl[0] = {8'h4D, 3'd3, 1'b1, 6'd1};
        pulse_start(7'd1);
        serve(2000, -1, 1'b0, 1'b0, dcnt, tmo);
        check("wide_timeout", tmo, 0);
        check("wide_done_cnt", dcnt, 1);
        check("wide_page0", word_at(0), 24'h7800B3);
        check("wide_lo0", word_at(1), 24'h78000D);
        check("wide_hi0", word_at(2), 24'h780014);
        check("wide_page1", word_at(19), 24'h7800B4);
        check("wide_lo1", word_at(20), 24'h78000D);
        check("wide_hi1", word_at(21), 24'h780014);
        compare_model("wide", 1);

        // Zero-glyph frame goes straight to FIN.
        pulse_start(7'd0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 1);
        check("zero_valid", cmd_valid, 0);
        step();
        check("zero_done_clear", done, 0);
        check("zero_idle", busy, 0);
        check("zero_valid_after", cmd_valid, 0);

        // Four glyphs, aborted on the 5th data word of glyph 2 while write_done is also high.
        desc_tbl[0] = {8'h10, 3'd1, 1'b0, 6'd5};
        desc_tbl[1] = {8'h22, 3'd2, 1'b0, 6'd9};
        desc_tbl[2] = {8'hF3, 3'd7, 1'b1, 6'd20};
        desc_tbl[3] = {8'h00, 3'd6, 1'b0, 6'd63};
        pulse_start(7'd4);
        serve(4000, 29, 1'b1, 1'b0, dcnt, tmo);
        check("abort_reached", tmo, 0);
        check("abort_words_before", got_q.size(), 29);
        check("abort_valid_low", cmd_valid, 0);
        check("abort_busy_low", busy, 0);
        dsum = 32'(done);
        for (int i = 0; i < 4; i++) begin
            step();
            dsum += 32'(done);
        end
        check("abort_no_done", dsum, 0);
        check("abort_stays_idle", busy, 0);

        pulse_start(7'd4);
        serve(4000, -1, 1'b0, 1'b0, dcnt, tmo);
        check("four_timeout", tmo, 0);
        check("four_done_cnt", dcnt, 1);
        check("four_page7_row0", word_at(44), 24'h7800B7);
        check("four_page7_row1", word_at(63), 24'h7800B0);
        check("four_hi_g2", word_at(46), 24'h78001F);
        compare_model("four", 4);

        // Start while busy must not disturb the frame in progress.
        desc_tbl[0] = {8'h5A, 3'd4, 1'b0, 6'd3};
        pulse_start(7'd1);
        step();
        check("busy_page_word", cmd_data, 24'h7800B4);
        start       = 1'b1;
        glyph_count = 7'd5;
        step();
        start = 1'b0;
        check("busy_start_data", cmd_data, 24'h7800B4);
        check("busy_start_valid", cmd_valid, 1);
        check("busy_start_idx", desc_idx, 0);
        serve(2000, -1, 1'b0, 1'b0, dcnt, tmo);
        check("busy_timeout", tmo, 0);
        check("busy_done_cnt", dcnt, 1);
        compare_model("busy", 1);

        // Reset in the middle of a frame, then a clean frame on a new start.
        desc_tbl[0] = {8'h10, 3'd1, 1'b0, 6'd5};
        pulse_start(7'd4);
        serve(4000, 10, 1'b0, 1'b0, dcnt, tmo);
        check("midrst_reached", tmo, 0);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        step();
        rst = 1'b0;
        step();
        step();
        check("midrst_no_restart", busy, 0);
        check("midrst_valid", cmd_valid, 0);
        pulse_start(7'd4);
        serve(4000, -1, 1'b0, 1'b0, dcnt, tmo);
        check("midrst_timeout", tmo, 0);
        check("midrst_done_cnt", dcnt, 1);
        compare_model("midrst", 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
